// File: rtl/pll_drp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pll_drp_arbiter
//  Description : Shares one PLL dynamic reconfiguration port between up to
//                eight requesters. Each requester gets a one-deep slot, slots
//                are granted round-robin, one DRP access runs at a time and
//                every access is bounded by a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_drp_arbiter #(
    parameter int g_num_ports = 2,
    parameter int g_timeout   = 255
) (
    input  logic                        clk_sys_i,
    input  logic                        rst_i,
    input  logic [g_num_ports-1:0]      den_i,
    input  logic [g_num_ports-1:0]      dwe_i,
    input  logic [5*g_num_ports-1:0]    daddr_i,
    input  logic [16*g_num_ports-1:0]   di_i,
    output logic [15:0]                 do_o,
    output logic [g_num_ports-1:0]      drdy_o,
    output logic [g_num_ports-1:0]      err_o,
    output logic [g_num_ports-1:0]      busy_o,
    output logic                        ovf_o,
    output logic                        tmo_o,
    input  logic                        clr_i,
    output logic                        pll_den_o,
    output logic                        pll_dwe_o,
    output logic [4:0]                  pll_daddr_o,
    output logic [15:0]                 pll_di_o,
    input  logic [15:0]                 pll_do_i,
    input  logic                        pll_drdy_i
);

    localparam int          c_IW       = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
    localparam logic [15:0] c_TMO_LAST = 16'(g_timeout - 1);
    localparam logic [15:0] c_TMO_DATA = 16'hDEAD;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;

    // Per-requester one-deep transaction slots
    logic [g_num_ports-1:0]         r_busy;
    logic [g_num_ports-1:0]         r_slot_dwe;
    logic [g_num_ports-1:0][4:0]    r_slot_addr;
    logic [g_num_ports-1:0][15:0]   r_slot_di;

    logic [c_IW-1:0]                r_last;
    logic [c_IW-1:0]                r_grant;
    logic [15:0]                    r_cnt;

    logic [15:0]                    r_do;
    logic [g_num_ports-1:0]         r_drdy;
    logic [g_num_ports-1:0]         r_err;
    logic                           r_ovf;
    logic                           r_tmo;
    logic                           r_pll_den;
    logic                           r_pll_dwe;
    logic [4:0]                     r_pll_daddr;
    logic [15:0]                    r_pll_di;

    logic [g_num_ports-1:0]         w_accept;
    logic [g_num_ports-1:0]         w_clr_mask;
    logic                           w_found;
    logic [c_IW-1:0]                w_sel;
    logic                           w_grant;
    logic                           w_done;
    logic                           w_tmo;

    // A strobe is taken only into an empty slot; anything else is an overflow
    assign w_accept = den_i & ~r_busy;

    // Round-robin search: walk offsets downward so the smallest offset above
    // the last grant is the one left standing
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = g_num_ports; i >= 1; i--) begin
            if (r_busy[(int'(r_last) + i) % g_num_ports]) begin
                w_found = 1'b1;
                w_sel   = c_IW'((int'(r_last) + i) % g_num_ports);
            end
        end
    end

    // State register
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_done       = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A ready arriving on the last allowed cycle still counts as success
                if (pll_drdy_i) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_tmo        = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Slot of the finishing access is released
    always_comb begin
        w_clr_mask = '0;
        if (w_done || w_tmo) begin
            w_clr_mask[r_grant] = 1'b1;
        end
    end

    // Slot capture, DRP drive, completion reporting and sticky flags
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_busy      <= '0;
            r_slot_dwe  <= '0;
            r_slot_addr <= '0;
            r_slot_di   <= '0;
            r_last      <= c_IW'(g_num_ports - 1);
            r_grant     <= '0;
            r_cnt       <= '0;
            r_do        <= '0;
            r_drdy      <= '0;
            r_err       <= '0;
            r_ovf       <= 1'b0;
            r_tmo       <= 1'b0;
            r_pll_den   <= 1'b0;
            r_pll_dwe   <= 1'b0;
            r_pll_daddr <= '0;
            r_pll_di    <= '0;
        end else begin
            r_drdy    <= '0;
            r_err     <= '0;
            r_pll_den <= 1'b0;
            r_pll_dwe <= 1'b0;

            for (int k = 0; k < g_num_ports; k++) begin
                if (w_accept[k]) begin
                    r_slot_dwe[k]  <= dwe_i[k];
                    r_slot_addr[k] <= daddr_i[5*k +: 5];
                    r_slot_di[k]   <= di_i[16*k +: 16];
                end
            end
            // Accept only hits empty slots and release only hits full ones
            r_busy <= (r_busy | w_accept) & ~w_clr_mask;

            if (w_grant) begin
                r_grant     <= w_sel;
                r_pll_den   <= 1'b1;
                r_pll_dwe   <= r_slot_dwe[w_sel];
                r_pll_daddr <= r_slot_addr[w_sel];
                r_pll_di    <= r_slot_di[w_sel];
                r_cnt       <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_done) begin
                r_do            <= pll_do_i;
                r_drdy[r_grant] <= 1'b1;
                r_last          <= r_grant;
            end else if (w_tmo) begin
                r_do            <= c_TMO_DATA;
                r_drdy[r_grant] <= 1'b1;
                r_err[r_grant]  <= 1'b1;
                r_last          <= r_grant;
            end

            // Sticky flags: a new event outranks a simultaneous clear
            if (|(den_i & r_busy)) begin
                r_ovf <= 1'b1;
            end else if (clr_i) begin
                r_ovf <= 1'b0;
            end
            if (w_tmo) begin
                r_tmo <= 1'b1;
            end else if (clr_i) begin
                r_tmo <= 1'b0;
            end
        end
    end

    assign do_o        = r_do;
    assign drdy_o      = r_drdy;
    assign err_o       = r_err;
    assign busy_o      = r_busy;
    assign ovf_o       = r_ovf;
    assign tmo_o       = r_tmo;
    assign pll_den_o   = r_pll_den;
    assign pll_dwe_o   = r_pll_dwe;
    assign pll_daddr_o = r_pll_daddr;
    assign pll_di_o    = r_pll_di;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_drp_arbiter
//  Description : Directed, table-driven bench for pll_drp_arbiter with a
//                behavioural DRP responder and an access monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_drp_arbiter;

    localparam int NP  = 2;
    localparam int TMO = 16;

    logic               clk_sys_i = 1'b0;
    logic               rst_i;
    logic [NP-1:0]      den_i, dwe_i;
    logic [5*NP-1:0]    daddr_i;
    logic [16*NP-1:0]   di_i;
    logic [15:0]        do_o;
    logic [NP-1:0]      drdy_o, err_o, busy_o;
    logic               ovf_o, tmo_o, clr_i;
    logic               pll_den_o, pll_dwe_o;
    logic [4:0]         pll_daddr_o;
    logic [15:0]        pll_di_o;
    logic [15:0]        pll_do_i;
    logic               pll_drdy_i;

    pll_drp_arbiter #(.g_num_ports(NP), .g_timeout(TMO)) dut (
        .clk_sys_i   (clk_sys_i),
        .rst_i       (rst_i),
        .den_i       (den_i),
        .dwe_i       (dwe_i),
        .daddr_i     (daddr_i),
        .di_i        (di_i),
        .do_o        (do_o),
        .drdy_o      (drdy_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o),
        .tmo_o       (tmo_o),
        .clr_i       (clr_i),
        .pll_den_o   (pll_den_o),
        .pll_dwe_o   (pll_dwe_o),
        .pll_daddr_o (pll_daddr_o),
        .pll_di_o    (pll_di_o),
        .pll_do_i    (pll_do_i),
        .pll_drdy_i  (pll_drdy_i)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Main process acts 2 time units after each rising edge
    task automatic tick();
        @(posedge clk_sys_i);
        #2;
    endtask

    // DRP responder: answers model_delay cycles after seeing pll_den_o
    int          model_delay = 3;
    bit          model_en    = 1'b1;
    bit          late_req    = 1'b0;
    logic [15:0] model_rdata = 16'h0000;
    int          rem         = 0;

    initial begin
        pll_drdy_i = 1'b0;
        pll_do_i   = 16'h0000;
        forever begin
            @(posedge clk_sys_i);
            #1;
            if (pll_drdy_i) pll_drdy_i = 1'b0;
            if (late_req) begin
                pll_drdy_i = 1'b1;
                pll_do_i   = 16'hBEEF;
                late_req   = 1'b0;
            end
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    pll_drdy_i = 1'b1;
                    pll_do_i   = model_rdata;
                end
            end
            if (pll_den_o && model_en) rem = model_delay;
        end
    end

    // Access monitor: logs every DRP access and counts completions per port
    int           cyc = 0;
    int           den_cnt = 0;
    int           den_cyc = 0;
    int           drdy_cyc = 0;
    int           drdy_cnt [NP];
    int           err_cnt  [NP];
    logic [21:0]  acc_q [$];

    initial begin
        for (int k = 0; k < NP; k++) begin
            drdy_cnt[k] = 0;
            err_cnt[k]  = 0;
        end
        forever begin
            @(posedge clk_sys_i);
            #1;
            cyc++;
            if (pll_den_o) begin
                den_cnt++;
                den_cyc = cyc;
                acc_q.push_back({pll_dwe_o, pll_daddr_o, pll_di_o});
            end
            for (int k = 0; k < NP; k++) begin
                if (drdy_o[k]) begin
                    drdy_cnt[k]++;
                    drdy_cyc = cyc;
                end
                if (err_o[k]) err_cnt[k]++;
            end
        end
    end

    task automatic clear_log();
        acc_q.delete();
        den_cnt = 0;
    endtask

    // One-cycle strobe from a single requester
    task automatic req(input int p, input logic we, input logic [4:0] a, input logic [15:0] d);
        den_i              = '0;
        den_i[p]           = 1'b1;
        dwe_i[p]           = we;
        daddr_i[5*p +: 5]  = a;
        di_i[16*p +: 16]   = d;
        tick();
        den_i              = '0;
    endtask

    task automatic wait_drdy(input int p, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (drdy_o[p]) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy_o == '0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {63'd0, ok}, 64'd1);
    endtask

    typedef struct {
        int          port;
        logic        dwe;
        logic [4:0]  addr;
        logic [15:0] di;
        logic [15:0] rdata;
        int          delay;
        logic [15:0] exp_do;
    } vec_t;

    vec_t vt [4];

    initial begin
        int c0;
        int e0;
        int d1;

        vt[0] = '{0, 1'b0, 5'h14, 16'h0000, 16'h1234, 3, 16'h1234};
        vt[1] = '{1, 1'b0, 5'h00, 16'h0000, 16'hFFFF, 1, 16'hFFFF};
        vt[2] = '{0, 1'b1, 5'h1F, 16'hA5A5, 16'h0000, 5, 16'h0000};
        vt[3] = '{1, 1'b1, 5'h0A, 16'h0001, 16'h7E81, 2, 16'h7E81};

        rst_i   = 1'b1;
        den_i   = '0;
        dwe_i   = '0;
        daddr_i = '0;
        di_i    = '0;
        clr_i   = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              {17'd0, do_o, drdy_o, err_o, busy_o, ovf_o, tmo_o, pll_den_o, pll_dwe_o, pll_daddr_o, pll_di_o},
              64'd0);
        rst_i = 1'b0;
        tick();

        // Single accesses, one per table row
        for (int v = 0; v < 4; v++) begin
            model_delay = vt[v].delay;
            model_rdata = vt[v].rdata;
            clear_log();
            req(vt[v].port, vt[v].dwe, vt[v].addr, vt[v].di);
            c0 = cyc;
            check($sformatf("v%0d_busy", v), {62'd0, busy_o}, 64'(1 << vt[v].port));
            wait_drdy(vt[v].port, $sformatf("v%0d_wait", v));
            check($sformatf("v%0d_do", v), {48'd0, do_o}, {48'd0, vt[v].exp_do});
            check($sformatf("v%0d_drdy", v), {62'd0, drdy_o}, 64'(1 << vt[v].port));
            check($sformatf("v%0d_err", v), {62'd0, err_o}, 64'd0);
            check($sformatf("v%0d_den_lat", v), 64'(den_cyc - c0), 64'd1);
            check($sformatf("v%0d_ndens", v), 64'(den_cnt), 64'd1);
            check($sformatf("v%0d_access", v), {42'd0, acc_q[0]},
                  {42'd0, vt[v].dwe, vt[v].addr, vt[v].di});
            tick();
            check($sformatf("v%0d_pulse", v), {60'd0, drdy_o, busy_o}, 64'd0);
        end

        // Round robin: both ports write at the same edge, three rounds. After
        // each round the last grant is port 1, so port 0 is always first.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        model_delay = 2;
        clear_log();
        for (int k = 0; k < NP; k++) drdy_cnt[k] = 0;
        for (int r = 0; r < 3; r++) begin
            den_i   = 2'b11;
            dwe_i   = 2'b11;
            daddr_i = {5'h02, 5'h01};
            di_i    = {16'h5555, 16'hAAAA};
            tick();
            den_i   = '0;
            wait_idle($sformatf("rr_idle%0d", r));
        end
        check("rr_count", 64'(acc_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < acc_q.size())
                check($sformatf("rr_order%0d", i), {48'd0, acc_q[i][15:0]},
                      (i % 2 == 0) ? 64'hAAAA : 64'h5555);
        end
        check("rr_drdy0", 64'(drdy_cnt[0]), 64'd3);
        check("rr_drdy1", 64'(drdy_cnt[1]), 64'd3);
        check("rr_ovf", {63'd0, ovf_o}, 64'd0);

        // Timeout: no ready ever comes back
        model_en = 1'b0;
        clear_log();
        req(0, 1'b0, 5'h03, 16'h0000);
        wait_drdy(0, "tmo_wait");
        check("tmo_latency", 64'(drdy_cyc - den_cyc), 64'(TMO));
        check("tmo_err", {60'd0, err_o, drdy_o}, {60'd0, 2'b01, 2'b01});
        check("tmo_do", {48'd0, do_o}, 64'hDEAD);
        check("tmo_flag", {63'd0, tmo_o}, 64'd1);
        d1 = drdy_cnt[0];
        late_req = 1'b1;
        repeat (4) tick();
        check("tmo_late_drdy", 64'(drdy_cnt[0] - d1), 64'd0);
        check("tmo_late_do", {48'd0, do_o}, 64'hDEAD);
        check("tmo_err_cnt", 64'(err_cnt[0]), 64'd1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("tmo_clr", {63'd0, tmo_o}, 64'd0);
        model_en = 1'b1;

        // Overflow: second strobe from port 1 while its slot is still full
        model_delay = 6;
        model_rdata = 16'h0C0C;
        clear_log();
        d1 = drdy_cnt[1];
        req(0, 1'b0, 5'h04, 16'h0000);
        req(1, 1'b1, 5'h05, 16'h1111);
        tick();
        req(1, 1'b1, 5'h06, 16'h2222);
        check("ovf_set", {63'd0, ovf_o}, 64'd1);
        wait_idle("ovf_idle");
        check("ovf_count", 64'(acc_q.size()), 64'd2);
        if (acc_q.size() > 1)
            check("ovf_p1_data", {42'd0, acc_q[1]}, {42'd0, 1'b1, 5'h05, 16'h1111});
        check("ovf_p1_drdy", 64'(drdy_cnt[1] - d1), 64'd1);
        // Clear and a fresh overflow at the same edge: the set wins
        req(0, 1'b0, 5'h04, 16'h0000);
        clr_i = 1'b1;
        req(0, 1'b0, 5'h04, 16'h0000);
        clr_i = 1'b0;
        check("ovf_set_wins", {63'd0, ovf_o}, 64'd1);
        wait_idle("ovf_idle2");
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("ovf_clr", {63'd0, ovf_o}, 64'd0);

        // Reset two cycles into WAIT
        model_delay = 5;
        model_rdata = 16'h5A5A;
        req(1, 1'b1, 5'h07, 16'h00FF);
        tick();
        tick();
        check("rst_inflight", {63'd0, busy_o[1]}, 64'd1);
        rst_i = 1'b1;
        rem   = 0;
        tick();
        rst_i = 1'b0;
        check("rst_outputs",
              {17'd0, do_o, drdy_o, err_o, busy_o, ovf_o, tmo_o, pll_den_o, pll_dwe_o, pll_daddr_o, pll_di_o},
              64'd0);
        d1 = drdy_cnt[1];
        repeat (8) tick();
        check("rst_no_drdy", 64'(drdy_cnt[1] - d1), 64'd0);
        model_delay = 3;
        model_rdata = 16'h4321;
        req(1, 1'b0, 5'h07, 16'h0000);
        wait_drdy(1, "rst_after_wait");
        check("rst_after_do", {48'd0, do_o}, 64'h4321);

        // Port 0 strobes again in the cycle its ready is showing
        model_delay = 2;
        model_rdata = 16'h0F0F;
        tick();
        req(0, 1'b1, 5'h08, 16'h0F0F);
        wait_drdy(0, "re_wait1");
        e0 = cyc;
        req(0, 1'b1, 5'h09, 16'hF0F0);
        check("re_accept", {63'd0, busy_o[0]}, 64'd1);
        check("re_no_ovf", {63'd0, ovf_o}, 64'd0);
        wait_drdy(0, "re_wait2");
        check("re_den_gap", 64'(den_cyc - e0), 64'd2);
        check("re_di", {48'd0, pll_di_o}, 64'hF0F0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
